// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the traffic phase controller and its environment.
// The slave side is the controller; the master side drives requests and watches lamps/display.
interface traffic_phase_ctrl_if;
    logic        ped_req;
    logic        emg_hold;
    logic [2:0]  out_LED3_NS;
    logic [2:0]  out_LED3_WE;
    logic [15:0] data;
    logic [1:0]  Stage;

    modport master (
        output ped_req,
        output emg_hold,
        input  out_LED3_NS,
        input  out_LED3_WE,
        input  data,
        input  Stage
    );

    modport slave (
        input  ped_req,
        input  emg_hold,
        output out_LED3_NS,
        output out_LED3_WE,
        output data,
        output Stage
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Four-phase intersection controller with a one-second prescaler, pedestrian green
// truncation, emergency all-red hold and a BCD countdown / cycle-count display.
module traffic_phase_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int T_NS_GREEN = 25,
    parameter int T_WE_GREEN = 20,
    parameter int T_YELLOW   = 3,
    parameter int T_PED      = 5
) (
    input logic              clk,
    input logic              rst_n,
    traffic_phase_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        WE_GREEN  = 2'd2,
        WE_YELLOW = 2'd3
    } phase_t;

    localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);
    localparam logic [6:0]  DUR_NS     = 7'(T_NS_GREEN);
    localparam logic [6:0]  DUR_WE     = 7'(T_WE_GREEN);
    localparam logic [6:0]  DUR_Y      = 7'(T_YELLOW);
    localparam logic [6:0]  DUR_PED    = 7'(T_PED);

    phase_t      state_q, state_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  cyc_hi_q, cyc_hi_d;
    logic [3:0]  cyc_lo_q, cyc_lo_d;
    logic [31:0] presc_q, presc_d;
    logic        ped_q, ped_d;
    logic        hold_q;
    logic        tick;
    logic        ped_eff;
    logic        is_green;

    function automatic logic [6:0] duration(input phase_t p);
        case (p)
            NS_GREEN: return DUR_NS;
            WE_GREEN: return DUR_WE;
            default:  return DUR_Y;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return WE_GREEN;
            WE_GREEN:  return WE_YELLOW;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NS_GREEN;
            rem_q    <= DUR_NS;
            cyc_hi_q <= 4'd0;
            cyc_lo_q <= 4'd0;
            presc_q  <= 32'd0;
            ped_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cyc_hi_q <= cyc_hi_d;
            cyc_lo_q <= cyc_lo_d;
            presc_q  <= presc_d;
            ped_q    <= ped_d;
            hold_q   <= bus.emg_hold;
        end
    end

    // A request seen this cycle acts immediately, so truncation lands one cycle after the pulse.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cyc_hi_d = cyc_hi_q;
        cyc_lo_d = cyc_lo_q;
        ped_d    = ped_q | bus.ped_req;
        ped_eff  = ped_q | bus.ped_req;
        is_green = (state_q == NS_GREEN) || (state_q == WE_GREEN);
        tick     = !bus.emg_hold && (presc_q == PRESC_LAST);

        if (bus.emg_hold) begin
            presc_d = 32'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = 32'd0;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        if (!bus.emg_hold) begin
            if (ped_eff && is_green && (rem_q > DUR_PED)) begin
                rem_d = DUR_PED;
            end else if (tick) begin
                if (rem_q == 7'd1) begin
                    state_d = next_phase(state_q);
                    rem_d   = duration(next_phase(state_q));
                    if ((state_q == NS_GREEN) || (state_q == WE_GREEN)) begin
                        ped_d = bus.ped_req;
                    end
                    if (state_q == WE_YELLOW) begin
                        if (cyc_lo_q == 4'd9) begin
                            cyc_lo_d = 4'd0;
                            cyc_hi_d = (cyc_hi_q == 4'd9) ? 4'd0 : cyc_hi_q + 4'd1;
                        end else begin
                            cyc_lo_d = cyc_lo_q + 4'd1;
                        end
                    end
                end else begin
                    rem_d = rem_q - 7'd1;
                end
            end
        end
    end

    // Lamps follow the registered hold flag so no input reaches an output combinationally.
    always_comb begin
        bus.out_LED3_NS = 3'b100;
        bus.out_LED3_WE = 3'b100;
        if (!hold_q) begin
            case (state_q)
                NS_GREEN: begin
                    bus.out_LED3_NS = 3'b001;
                    bus.out_LED3_WE = 3'b100;
                end
                NS_YELLOW: begin
                    bus.out_LED3_NS = 3'b010;
                    bus.out_LED3_WE = 3'b100;
                end
                WE_GREEN: begin
                    bus.out_LED3_NS = 3'b100;
                    bus.out_LED3_WE = 3'b001;
                end
                default: begin
                    bus.out_LED3_NS = 3'b100;
                    bus.out_LED3_WE = 3'b010;
                end
            endcase
        end
        bus.data  = {to_bcd(rem_q), cyc_hi_q, cyc_lo_q};
        bus.Stage = state_q;
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: stimulus queues hand-computed snapshots stamped
// with a clock-edge index; a negedge monitor compares the DUT when that edge is reached.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_ctrl_if bus();

    traffic_phase_ctrl #(
        .TICK_DIV   (4),
        .T_NS_GREEN (6),
        .T_WE_GREEN (4),
        .T_YELLOW   (2),
        .T_PED      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          at;
        logic [2:0]  ns;
        logic [2:0]  we;
        logic [15:0] data;
        logic [1:0]  stage;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic pushExpect(input int at, input logic [2:0] ns, input logic [2:0] we,
                              input logic [15:0] d, input logic [1:0] st, input string name);
        exp_t e;
        e.at    = at;
        e.ns    = ns;
        e.we    = we;
        e.data  = d;
        e.stage = st;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic pushPhase(input int at, input logic [1:0] st, input logic [15:0] d,
                             input string name);
        case (st)
            2'd0:    pushExpect(at, 3'b001, 3'b100, d, st, name);
            2'd1:    pushExpect(at, 3'b010, 3'b100, d, st, name);
            2'd2:    pushExpect(at, 3'b100, 3'b001, d, st, name);
            default: pushExpect(at, 3'b100, 3'b010, d, st, name);
        endcase
    endtask

    task automatic applyStimulus(input logic ped, input logic hold, input int n);
        bus.ped_req  = ped;
        bus.emg_hold = hold;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.out_LED3_NS !== e.ns || bus.out_LED3_WE !== e.we ||
            bus.data !== e.data || bus.Stage !== e.stage) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got NS=%b WE=%b data=%h Stage=%0d, expected NS=%b WE=%b data=%h Stage=%0d",
                     e.name, e.at, bus.out_LED3_NS, bus.out_LED3_WE, bus.data, bus.Stage,
                     e.ns, e.we, e.data, e.stage);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= edges) begin
            mon_e = sb.pop_front();
            if (mon_e.at < edges) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for edge %0d not sampled, now at edge %0d",
                         mon_e.name, mon_e.at, edges);
            end else begin
                checkOutput(mon_e);
            end
        end
    end

    initial begin
        bus.ped_req  = 1'b0;
        bus.emg_hold = 1'b0;
        rst_n        = 1'b0;

        applyStimulus(1'b0, 1'b0, 3);
        pushPhase(edges, 2'd0, 16'h0600, "reset_hold");
        applyStimulus(1'b0, 1'b0, 1);

        // Free-running cycle from reset release
        rst_n = 1'b1;
        base  = edges;
        pushPhase(base + 0,  2'd0, 16'h0600, "t1_release");
        pushPhase(base + 3,  2'd0, 16'h0600, "t1_pre_tick");
        pushPhase(base + 4,  2'd0, 16'h0500, "t1_first_tick");
        pushPhase(base + 23, 2'd0, 16'h0100, "t1_last_ns_green");
        pushPhase(base + 24, 2'd1, 16'h0200, "t1_ns_yellow");
        pushPhase(base + 32, 2'd2, 16'h0400, "t1_we_green");
        pushPhase(base + 48, 2'd3, 16'h0200, "t1_we_yellow");
        pushPhase(base + 55, 2'd3, 16'h0100, "t1_end_cycle");
        pushPhase(base + 56, 2'd0, 16'h0601, "t1_cycle_done");
        applyStimulus(1'b0, 1'b0, 56);

        // Pedestrian truncation at remaining 6
        base = edges;
        pushPhase(base + 1,  2'd0, 16'h0301, "t2_truncate");
        pushPhase(base + 4,  2'd0, 16'h0201, "t2_tick_after_trunc");
        pushPhase(base + 11, 2'd0, 16'h0101, "t2_last_green");
        pushPhase(base + 12, 2'd1, 16'h0201, "t2_ns_yellow");
        pushPhase(base + 20, 2'd2, 16'h0401, "t2_we_green");
        pushPhase(base + 21, 2'd2, 16'h0401, "t2_latch_cleared");
        pushPhase(base + 24, 2'd2, 16'h0301, "t2_we_tick");
        pushPhase(base + 44, 2'd0, 16'h0602, "t2_cycle_done");
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 43);

        // Pedestrian request with remaining below the truncation length
        base = edges;
        pushPhase(base + 16, 2'd0, 16'h0202, "t3_rem2");
        pushPhase(base + 17, 2'd0, 16'h0202, "t3_no_truncate");
        pushPhase(base + 24, 2'd1, 16'h0202, "t3_ns_yellow");
        pushPhase(base + 33, 2'd2, 16'h0402, "t3_we_full");
        pushPhase(base + 47, 2'd2, 16'h0102, "t3_we_last");
        pushPhase(base + 48, 2'd3, 16'h0202, "t3_we_yellow");
        pushPhase(base + 56, 2'd0, 16'h0603, "t3_cycle_done");
        applyStimulus(1'b0, 1'b0, 16);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 39);

        // Emergency hold in WE green at remaining 3
        base = edges;
        pushPhase (base + 36, 2'd2, 16'h0303, "t4_rem3");
        pushExpect(base + 37, 3'b100, 3'b100, 16'h0303, 2'd2, "t4_hold_enter");
        pushExpect(base + 46, 3'b100, 3'b100, 16'h0303, 2'd2, "t4_hold_end");
        pushPhase (base + 47, 2'd2, 16'h0303, "t4_resume");
        pushPhase (base + 49, 2'd2, 16'h0303, "t4_no_early_tick");
        pushPhase (base + 50, 2'd2, 16'h0203, "t4_first_tick");
        pushPhase (base + 58, 2'd3, 16'h0203, "t4_we_yellow");
        pushPhase (base + 66, 2'd0, 16'h0604, "t4_cycle_done");
        applyStimulus(1'b0, 1'b0, 36);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 20);

        // Long run for BCD carry and 99 -> 00 wrap
        base = edges;
        pushPhase(base + 336,  2'd0, 16'h0610, "t5_bcd_carry");
        pushPhase(base + 5319, 2'd3, 16'h0198, "t5_cycle98");
        pushPhase(base + 5320, 2'd0, 16'h0699, "t5_cycle99");
        pushPhase(base + 5376, 2'd0, 16'h0600, "t5_wrap");
        applyStimulus(1'b0, 1'b0, 5376);

        // Asynchronous reset in WE yellow
        base = edges;
        pushPhase(base + 49, 2'd3, 16'h0200, "t6_in_we_yellow");
        applyStimulus(1'b0, 1'b0, 50);
        rst_n = 1'b0;
        pushPhase(edges, 2'd0, 16'h0600, "t6_async_reset");
        applyStimulus(1'b0, 1'b0, 3);
        rst_n = 1'b1;
        base  = edges;
        pushPhase(base,     2'd0, 16'h0600, "t6_release");
        pushPhase(base + 4, 2'd0, 16'h0500, "t6_restart_tick");
        applyStimulus(1'b0, 1'b0, 6);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for edge %0d never sampled", mon_e.name, mon_e.at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
